mult_share_arbiter: RTL and testbench

- Shares one fixed-latency, non-stallable pipelined multiplier (a*b -> 2*WIDTH product, one issue per cycle) between NUM_REQ requesters.
- Performs round-robin arbitration with a valid/ready request handshake and per-requester outstanding-credit limits.
- Carries a requester tag alongside each operation, matched to the multiplier latency.
- Routes each product back to its originator as a one-cycle response pulse on a shared result bus.
- Sits between client datapaths and the multiplier instance. Drives the multiplier operands directly and samples its result port.

---
 rtl/mult_share_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mult_share_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one fixed-latency, non-stallable pipelined multiplier
// between NUM_REQ requesters.
//   - Arbitration is round-robin with a valid/ready request handshake and
//     per-requester outstanding-credit limits; at most one op issues per cycle.
//   - A requester tag travels alongside each op through a shift register that
//     matches the multiplier depth.
//   - Each product returns to its originator as a one-cycle pulse on a shared
//     result bus.
//   - Response latency is MUL_LATENCY+1 cycles from accept. There is no response
//     backpressure.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   req_valid/req_ready       per-requester handshake; ready is one-hot or zero
//   req_a/req_b               packed operands, requester i at [i*WIDTH +: WIDTH]
//   mul_a/mul_b/mul_result    drive the attached multiplier and sample its product
//   rsp_valid/rsp_data        one-hot response pulse and its product
//   busy                      high while any operation is in flight
module mult_share_arbiter #(
   parameter int WIDTH       = 16,
   parameter int NUM_REQ     = 4,
   parameter int MUL_LATENCY = 5,
   parameter int MAX_OUT     = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [WIDTH-1:0]         mul_a,
   output logic [WIDTH-1:0]         mul_b,
   input  logic [2*WIDTH-1:0]       mul_result,
   output logic [NUM_REQ-1:0]       rsp_valid,
   output logic [2*WIDTH-1:0]       rsp_data,
   output logic                     busy
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_OUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

   logic [ID_W-1:0]        last_grant;
   logic [CNT_W-1:0]       outstanding [NUM_REQ];
   logic [NUM_REQ-1:0]     eligible;
   logic [NUM_REQ-1:0]     grant;
   logic [ID_W-1:0]        grant_id;
   logic                   accept;
   logic [MUL_LATENCY-1:0] tag_vld;
   logic [ID_W-1:0]        tag_id [MUL_LATENCY];

   // Eligibility uses the registered credit count, so a returned credit can be
   // reused from the cycle after the response pulse. It is gated by rst so that
   // nothing is accepted while the block is held in reset.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = !rst && req_valid[i] && (outstanding[i] < CNT_MAX);
      end
   end

   // Round-robin search starting one past the last winner.
   always_comb begin
      int  idx;
      logic found;
      idx      = 0;
      found    = 1'b0;
      grant    = '0;
      grant_id = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(last_grant) + 1 + k) % NUM_REQ;
         if (!found && eligible[idx]) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            grant_id    = ID_W'(idx);
         end
      end
   end

   // A grant is only ever issued to a requester that is valid, so a nonzero
   // grant is an accept.
   assign req_ready = grant;
   assign accept    = |grant;

   // Operand mux. Idle cycles drive zero. The multiplier still produces a
   // product on those cycles, but it never carries a valid tag.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            mul_a = req_a[i*WIDTH +: WIDTH];
            mul_b = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // Tag ids need no reset: they are only ever looked at under a valid bit.
   always_ff @(posedge clk) begin
      tag_id[0] <= grant_id;
      for (int s = 1; s < MUL_LATENCY; s++) begin
         tag_id[s] <= tag_id[s-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // Clearing the tag valids drops every in-flight op. Stale products
         // still leaving the multiplier are ignored.
         last_grant <= ID_W'(NUM_REQ - 1);
         tag_vld    <= '0;
         rsp_valid  <= '0;
         rsp_data   <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            outstanding[i] <= '0;
         end
      end else begin
         if (accept) begin
            last_grant <= grant_id;
         end

         tag_vld[0] <= accept;
         for (int s = 1; s < MUL_LATENCY; s++) begin
            tag_vld[s] <= tag_vld[s-1];
         end

         // The last tag stage lines up with the product on mul_result.
         if (tag_vld[MUL_LATENCY-1]) begin
            rsp_valid <= NUM_REQ'(1) << tag_id[MUL_LATENCY-1];
            rsp_data  <= mul_result;
         end else begin
            rsp_valid <= '0;
         end

         // A credit is returned on the edge that ends the response pulse.
         // An accept and a return on the same edge cancel each other out.
         for (int i = 0; i < NUM_REQ; i++) begin
            case ({grant[i], rsp_valid[i]})
               2'b10:   outstanding[i] <= outstanding[i] + CNT_W'(1);
               2'b01:   outstanding[i] <= outstanding[i] - CNT_W'(1);
               default: outstanding[i] <= outstanding[i];
            endcase
         end
      end
   end

   always_comb begin
      busy = (|tag_vld) || (|rsp_valid);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (outstanding[i] != '0) begin
            busy = 1'b1;
         end
      end
   end

   // Credit accounting must never underflow or exceed its limit.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_credit_chk
      a_no_underflow : assert property (@(posedge clk) disable iff (rst)
         !(rsp_valid[g] && !grant[g] && outstanding[g] == '0));
      a_no_overflow : assert property (@(posedge clk) disable iff (rst)
         !(grant[g] && outstanding[g] >= CNT_MAX));
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with behavioural multiplier pipelines.
// Main instance uses MAX_OUT=2; a second instance with MAX_OUT=7 covers the
// streaming case where accepts and credit returns coincide.
module tb_mult_share_arbiter;

   localparam int W = 16;
   localparam int N = 4;
   localparam int L = 5;

   logic clk;
   logic rst;
   logic [N-1:0]   req_valid, req_ready, rsp_valid;
   logic [N*W-1:0] req_a, req_b;
   logic [W-1:0]   mul_a, mul_b;
   logic [2*W-1:0] mul_result, rsp_data;
   logic           busy;

   logic [N-1:0]   req_valid7, req_ready7, rsp_valid7;
   logic [N*W-1:0] req_a7, req_b7;
   logic [W-1:0]   mul_a7, mul_b7;
   logic [2*W-1:0] mul_result7, rsp_data7;
   logic           busy7;

   logic [2*W-1:0] mpipe  [L];
   logic [2*W-1:0] mpipe7 [L];

   typedef struct {
      int          due;
      logic [3:0]  oh;
      logic [31:0] prod;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] op_a [N];
   logic [15:0] op_b [N];
   int          cyc;
   int          n_vec;
   int          n_bad;

   mult_share_arbiter #(.WIDTH(W), .NUM_REQ(N), .MUL_LATENCY(L), .MAX_OUT(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b),
      .mul_result(mul_result), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
   );

   mult_share_arbiter #(.WIDTH(W), .NUM_REQ(N), .MUL_LATENCY(L), .MAX_OUT(7)) dut7 (
      .clk(clk), .rst(rst), .req_valid(req_valid7), .req_ready(req_ready7),
      .req_a(req_a7), .req_b(req_b7), .mul_a(mul_a7), .mul_b(mul_b7),
      .mul_result(mul_result7), .rsp_valid(rsp_valid7), .rsp_data(rsp_data7), .busy(busy7)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multipliers of depth L, never reset.
   always @(posedge clk) begin
      mpipe[0]  <= 32'(mul_a) * 32'(mul_b);
      mpipe7[0] <= 32'(mul_a7) * 32'(mul_b7);
      for (int k = 1; k < L; k++) begin
         mpipe[k]  <= mpipe[k-1];
         mpipe7[k] <= mpipe7[k-1];
      end
   end
   assign mul_result  = mpipe[L-1];
   assign mul_result7 = mpipe7[L-1];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   // One cycle on the main instance: drive at posedge+1, check at negedge,
   // then record the expected response for each expected accept.
   task automatic step(input logic [3:0] vld, input logic [3:0] exp_rdy, input logic rst_v);
      logic [15:0] ea, eb;
      @(posedge clk);
      if (rst) exp_q.delete();
      #1;
      cyc++;
      rst       = rst_v;
      req_valid = vld;
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = op_a[i];
         req_b[i*W +: W] = op_b[i];
      end
      @(negedge clk);
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      ea = '0;
      eb = '0;
      for (int i = 0; i < N; i++) begin
         if (exp_rdy[i]) begin
            ea = op_a[i];
            eb = op_b[i];
         end
      end
      check("mul_a", 64'(mul_a), 64'(ea));
      check("mul_b", 64'(mul_b), 64'(eb));
      check("busy", 64'(busy), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
         check("rsp_valid", 64'(rsp_valid), 64'(exp_q[0].oh));
         check("rsp_data", 64'(rsp_data), 64'(exp_q[0].prod));
         void'(exp_q.pop_front());
      end else begin
         check("rsp_idle", 64'(rsp_valid), 64'(0));
      end
      for (int i = 0; i < N; i++) begin
         if (exp_rdy[i] && vld[i]) begin
            exp_q.push_back('{due: cyc + L + 1, oh: 4'(1) << i,
                              prod: 32'(op_a[i]) * 32'(op_b[i])});
            op_a[i] = op_a[i] + 16'h0011;
            op_b[i] = op_b[i] + 16'h0203;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(4'b0000, 4'b0000, 1'b0);
   endtask

   // Streaming on the MAX_OUT=7 instance: requester 3 valid for 12 cycles.
   task automatic run_max7();
      int lo, hi, exp_out;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         req_valid7 = (c < 12) ? 4'b1000 : 4'b0000;
         @(negedge clk);
         check("m7_ready", 64'(req_ready7), (c < 12) ? 64'h8 : 64'h0);
         lo = (c - 6 > 0) ? c - 6 : 0;
         hi = (c - 1 < 11) ? c - 1 : 11;
         exp_out = (hi >= lo) ? hi - lo + 1 : 0;
         check("m7_outstanding", 64'(dut7.outstanding[3]), 64'(exp_out));
         check("m7_rsp_valid", 64'(rsp_valid7), (c >= 6 && c <= 17) ? 64'h8 : 64'h0);
         if (c >= 6 && c <= 17) check("m7_rsp_data", 64'(rsp_data7), 64'h0003_0A08);
         check("m7_busy", 64'(busy7), 64'(c >= 1 && c <= 17));
      end
   endtask

   initial begin
      logic [9:0] pat;
      logic [3:0] e;
      n_vec = 0;
      n_bad = 0;
      cyc   = 0;
      rst   = 1'b1;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      req_valid7 = '0;
      req_a7     = {16'h0102, 48'h0};
      req_b7     = {16'h0304, 48'h0};
      for (int i = 0; i < N; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
      end

      // Reset: ready gated off even with all requesters valid.
      step(4'b1111, 4'b0000, 1'b1);
      step(4'b1111, 4'b0000, 1'b1);

      // Single op on requester 0.
      op_a[0] = 16'h0003;
      op_b[0] = 16'h0007;
      step(4'b0001, 4'b0001, 1'b0);
      idle(7);
      check("t1_hold", 64'(rsp_data), 64'h0000_0015);

      // Max operands on requester 2.
      op_a[2] = 16'hFFFF;
      op_b[2] = 16'hFFFF;
      step(4'b0100, 4'b0100, 1'b0);
      idle(7);
      check("t2_hold", 64'(rsp_data), 64'hFFFE_0001);

      // Round-robin with all four requesters streaming.
      step(4'b0000, 4'b0000, 1'b1);
      for (int i = 0; i < N; i++) begin
         op_a[i] = 16'(16'h1000 * (i + 1) + 16'h0010);
         op_b[i] = 16'(16'h0101 * (i + 2));
      end
      for (int k = 0; k < 12; k++) begin
         e = 4'b0001 << (k % 4);
         step(4'b1111, e, 1'b0);
      end
      idle(7);

      // Credit limit: requester 1 alone, MAX_OUT=2.
      step(4'b0000, 4'b0000, 1'b1);
      op_a[1] = 16'h0123;
      op_b[1] = 16'h0456;
      pat = 10'b01_1000_0011;
      for (int k = 0; k < 10; k++) begin
         step(4'b0010, pat[k] ? 4'b0010 : 4'b0000, 1'b0);
      end
      idle(8);

      // Accept and credit return on the same edge.
      run_max7();

      // Reset while three ops are in flight.
      step(4'b0000, 4'b0000, 1'b1);
      op_a[0] = 16'h0011; op_b[0] = 16'h0022;
      op_a[1] = 16'h0033; op_b[1] = 16'h0044;
      op_a[2] = 16'h0055; op_b[2] = 16'h0066;
      step(4'b0111, 4'b0001, 1'b0);
      step(4'b0110, 4'b0010, 1'b0);
      step(4'b0100, 4'b0100, 1'b0);
      step(4'b0000, 4'b0000, 1'b0);
      step(4'b0000, 4'b0000, 1'b1);
      idle(6);
      check("flush_outstanding0", 64'(dut.outstanding[0]), 64'h0);
      op_a[0] = 16'h0009;
      op_b[0] = 16'h000B;
      step(4'b0001, 4'b0001, 1'b0);
      idle(7);
      check("fresh_hold", 64'(rsp_data), 64'h0000_0063);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
